// File: rtl/lap_stopwatch.sv
// BCD tenth-second stopwatch with prescaler, circular lap buffer and frozen-lap display.
// Define LAP_RECALL_EN to add the S3 button that browses stored laps while stopped.
module lap_stopwatch #(
  parameter int DIGITS    = 3,
  parameter int TICK_DIV  = 5000000,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           S1,
  input  logic                           S2,
`ifdef LAP_RECALL_EN
  input  logic                           S3,
`endif
  output logic [7*DIGITS-1:0]            hex,
  output logic                           running,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           overflow
);

  localparam int CW    = $clog2(LAP_DEPTH + 1);
  localparam int PW    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int BW    = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

  state_t           state, state_nxt;
  logic             s1_q, s2_q, s1_rise, s2_rise;
  logic             counting, tick, capture, clear;
  logic [PRE_W-1:0] pre;
  logic [BW-1:0]    count, count_inc, disp;
  logic             wrap;
  logic [BW-1:0]    laps [LAP_DEPTH];
  logic [PW-1:0]    wr_ptr, newest;

  assign s1_rise  = S1 & ~s1_q;
  assign s2_rise  = S2 & ~s2_q;
  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (pre == PRE_W'(TICK_DIV - 1));
  assign running  = counting;
  assign newest   = (wr_ptr == '0) ? PW'(LAP_DEPTH - 1) : wr_ptr - 1'b1;

  // S1 is tested first everywhere so a simultaneous S2 edge is dropped.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: if (s1_rise) state_nxt = RUN;
      RUN: begin
        if (s1_rise) state_nxt = STOP;
        else if (s2_rise) begin
          state_nxt = LAP;
          capture   = 1'b1;
        end
      end
      LAP: begin
        if (s1_rise) state_nxt = STOP;
        else if (s2_rise) state_nxt = RUN;
      end
      STOP: begin
        if (s1_rise) state_nxt = RUN;
        else if (s2_rise) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    logic carry;
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) count_inc[4*i +: 4] = 4'd0;
        else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      pre       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      lap_count <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
    end else begin
      state <= state_nxt;
      s1_q  <= S1;
      s2_q  <= S2;
      if (clear) begin
        pre       <= '0;
        count     <= '0;
        overflow  <= 1'b0;
        wr_ptr    <= '0;
        lap_count <= '0;
        for (int i = 0; i < LAP_DEPTH; i++) laps[i] <= '0;
      end else begin
        if (counting) pre <= tick ? '0 : pre + 1'b1;
        else if (state == IDLE) pre <= '0;
        if (tick) begin
          count <= count_inc;
          if (wrap) overflow <= 1'b1;
        end
        // The lap stores the pre-increment value even when a tick lands on the same edge.
        if (capture) begin
          laps[wr_ptr] <= count;
          wr_ptr       <= (wr_ptr == PW'(LAP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
          if (lap_count != CW'(LAP_DEPTH)) lap_count <= lap_count + 1'b1;
        end
      end
    end
  end

`ifdef LAP_RECALL_EN
  logic          s3_q, s3_rise;
  logic [CW-1:0] rd_idx;
  logic [PW-1:0] rd_sel;
  int            sel;

  assign s3_rise = S3 & ~s3_q;

  // rd_idx 0 means live; 1..lap_count walks from the newest lap to the oldest.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_q   <= 1'b0;
      rd_idx <= '0;
    end else begin
      s3_q <= S3;
      if (state_nxt != state) rd_idx <= '0;
      else if ((state == STOP) && s3_rise && (lap_count != '0))
        rd_idx <= (rd_idx == lap_count) ? '0 : rd_idx + 1'b1;
    end
  end

  always_comb begin
    sel = int'(wr_ptr) - int'(rd_idx);
    if (sel < 0) sel = sel + LAP_DEPTH;
    rd_sel = PW'(sel);
  end

  always_comb begin
    disp = count;
    if (state == LAP) disp = laps[newest];
    else if ((state == STOP) && (rd_idx != '0)) disp = laps[rd_sel];
  end
`else
  always_comb begin
    disp = count;
    if (state == LAP) disp = laps[newest];
  end
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    hex = '1;
    for (int i = 0; i < DIGITS; i++) hex[7*i +: 7] = seg7(disp[4*i +: 4]);
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed-plus-random bench for lap_stopwatch, checked against an integer/queue model.
// Exercises the S3 recall path when LAP_RECALL_EN is defined.
module tb_lap_stopwatch;

  localparam int DIGITS    = 3;
  localparam int TICK_DIV  = 4;
  localparam int LAP_DEPTH = 2;
  localparam int CW        = $clog2(LAP_DEPTH + 1);
  localparam int MODULUS   = 10 ** DIGITS;
`ifdef LAP_RECALL_EN
  localparam bit RECALL = 1'b1;
`else
  localparam bit RECALL = 1'b0;
`endif

  typedef enum {M_IDLE, M_RUN, M_STOP, M_LAP} mode_t;

  logic                  clk = 1'b0;
  logic                  reset, S1, S2;
  logic [7*DIGITS-1:0]   hex;
  logic                  running, overflow;
  logic [CW-1:0]         lap_count;
`ifdef LAP_RECALL_EN
  logic                  S3;
`endif

  mode_t m_mode = M_IDLE;
  int    m_cnt = 0, m_pre = 0, m_rd = 0;
  bit    m_ovf = 1'b0, p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
  int    lapq[$];
  int    passed = 0, failed = 0, total = 0;

  lap_stopwatch #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .S1(S1),
    .S2(S2),
`ifdef LAP_RECALL_EN
    .S3(S3),
`endif
    .hex(hex),
    .running(running),
    .lap_count(lap_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] hexOf(input int value);
    logic [7*DIGITS-1:0] r;
    int v;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = segOf(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int shownValue();
    if (m_mode == M_LAP) return lapq[lapq.size() - 1];
    if ((m_mode == M_STOP) && (m_rd > 0)) return lapq[lapq.size() - m_rd];
    return m_cnt;
  endfunction

  // One clock of stopwatch behaviour, phrased as what a user would see happen.
  function automatic void modelUpdate(input bit rst, input bit b1, input bit b2, input bit b3);
    bit r1, r2, r3;
    mode_t old_mode;
    int old_cnt;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_pre = 0; m_rd = 0; m_ovf = 1'b0;
      p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
      lapq.delete();
      return;
    end
    r1 = b1 && !p1; r2 = b2 && !p2; r3 = RECALL && b3 && !p3;
    p1 = b1; p2 = b2; p3 = RECALL && b3;
    old_mode = m_mode;
    old_cnt  = m_cnt;
    if ((m_mode == M_RUN) || (m_mode == M_LAP)) begin
      if (m_pre == TICK_DIV - 1) begin
        m_pre = 0;
        m_cnt = m_cnt + 1;
        if (m_cnt == MODULUS) begin
          m_cnt = 0;
          m_ovf = 1'b1;
        end
      end else m_pre = m_pre + 1;
    end
    case (old_mode)
      M_IDLE: if (r1) m_mode = M_RUN;
      M_RUN: begin
        if (r1) m_mode = M_STOP;
        else if (r2) begin
          lapq.push_back(old_cnt);
          if (lapq.size() > LAP_DEPTH) void'(lapq.pop_front());
          m_mode = M_LAP;
        end
      end
      M_LAP: begin
        if (r1) m_mode = M_STOP;
        else if (r2) m_mode = M_RUN;
      end
      M_STOP: begin
        if (r1) m_mode = M_RUN;
        else if (r2) begin
          m_mode = M_IDLE; m_cnt = 0; m_pre = 0; m_ovf = 1'b0;
          lapq.delete();
        end
      end
      default: m_mode = M_IDLE;
    endcase
    if (m_mode != old_mode) m_rd = 0;
    else if ((old_mode == M_STOP) && r3 && (lapq.size() > 0))
      m_rd = (m_rd == lapq.size()) ? 0 : m_rd + 1;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the model advances with the DUT's rising edge.
  task automatic applyStimulus(input bit rst, input bit b1, input bit b2, input bit b3);
    reset = rst; S1 = b1; S2 = b2;
`ifdef LAP_RECALL_EN
    S3 = b3;
`endif
    @(posedge clk);
    modelUpdate(rst, b1, b2, b3);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " hex"}, 32'(hex), 32'(hexOf(shownValue())));
    checkVal({tag, " running"}, 32'(running), 32'((m_mode == M_RUN) || (m_mode == M_LAP)));
    checkVal({tag, " lap_count"}, 32'(lap_count), 32'(lapq.size()));
    checkVal({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic press(input bit b1, input bit b2, input bit b3, input string tag);
    applyStimulus(1'b0, b1, b2, b3);
    checkOutput({tag, " press"});
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " release"});
  endtask

  task automatic runUntil(input int target, input bit on_tick, input int budget, input string tag);
    int n = 0;
    while (!((m_cnt == target) && (!on_tick || (m_pre == TICK_DIV - 1))) && (n < budget)) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput(tag);
      n++;
    end
    checkVal({tag, " reached within budget"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    reset = 1'b1; S1 = 1'b0; S2 = 1'b0;
`ifdef LAP_RECALL_EN
    S3 = 1'b0;
`endif
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset");
    checkVal("reset hex all zero", 32'(hex), 32'({DIGITS{7'b1000000}}));

    // 40 counting clocks at TICK_DIV=4 is exactly one second.
    press(1'b1, 1'b0, 1'b0, "start");
    for (int i = 0; i < 39; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("run40");
    end
    checkVal("one second hex", 32'(hex), 32'({7'b1000000, 7'b1111001, 7'b1000000}));
    checkVal("one second running", 32'(running), 32'd1);

    runUntil(MODULUS - 1, 1'b1, 5000, "to999");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap");
    checkVal("wrap hex", 32'(hex), 32'(hexOf(0)));
    checkVal("wrap overflow", 32'(overflow), 32'd1);
    press(1'b1, 1'b0, 1'b0, "stop");
    press(1'b0, 1'b1, 1'b0, "clear");
    checkVal("clear overflow", 32'(overflow), 32'd0);

    // Lap pressed on the very edge where 005 would advance to 006.
    press(1'b1, 1'b0, 1'b0, "start2");
    runUntil(5, 1'b1, 200, "to005");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lap on tick");
    checkVal("lap frozen hex", 32'(hex), 32'(hexOf(5)));
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("frozen");
    end
    checkVal("still frozen hex", 32'(hex), 32'(hexOf(5)));
    press(1'b0, 1'b1, 1'b0, "back live");

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 7) == 0, RECALL && ($urandom_range(0, 5) == 0));
      checkOutput("random");
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset2");
    press(1'b1, 1'b0, 1'b0, "start3");
    runUntil(3, 1'b0, 100, "to003");
    press(1'b0, 1'b1, 1'b0, "lap003");
    press(1'b0, 1'b1, 1'b0, "live003");
    runUntil(7, 1'b0, 100, "to007");
    press(1'b0, 1'b1, 1'b0, "lap007");
    press(1'b0, 1'b1, 1'b0, "live007");
    runUntil(12, 1'b0, 100, "to012");
    press(1'b0, 1'b1, 1'b0, "lap012");
    checkVal("three laps count", 32'(lap_count), 32'd2);
    checkVal("three laps newest", 32'(hex), 32'(hexOf(12)));
    press(1'b1, 1'b0, 1'b0, "stop laps");
`ifdef LAP_RECALL_EN
    press(1'b0, 1'b0, 1'b1, "recall1");
    checkVal("recall newest", 32'(hex), 32'(hexOf(12)));
    press(1'b0, 1'b0, 1'b1, "recall2");
    checkVal("recall oldest", 32'(hex), 32'(hexOf(7)));
    press(1'b0, 1'b0, 1'b1, "recall3");
    checkVal("recall live", 32'(hex), 32'(hexOf(m_cnt)));
`endif

    press(1'b1, 1'b0, 1'b0, "restart");
    press(1'b1, 1'b1, 1'b0, "s1s2 same cycle");
    checkVal("s1s2 running", 32'(running), 32'd0);
    checkVal("s1s2 no lap", 32'(lap_count), 32'd2);
    press(1'b1, 1'b0, 1'b0, "restart2");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pre-reset run");
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("reset mid-run");
    checkVal("reset mid-run hex", 32'(hex), 32'({DIGITS{7'b1000000}}));
    checkVal("reset mid-run laps", 32'(lap_count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
